// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the mem_arbiter slice.
//   state_e     - arbiter FSM states (IDLE, ISSUE, DONE)
//   DEF_*       - default requester count and memory geometry (256x32)
//   owner_w()   - width of an owner/last index for a given requester count
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 32;

  function automatic int unsigned owner_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side bundle of mem_arbiter.
//   req/req_rw/req_addr/req_wdata  - packed per-requester level requests
//   grant/done/rd_data/busy        - owner indication and completion
//   mem_*                          - single-port sharedMemory connection
//   req_lock                       - only when MEM_ARB_LOCK_EN is defined
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
`ifdef MEM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_address;
  logic                      mem_read_write;
  logic [DATA_W-1:0]         mem_data_in;
  logic                      mem_enabled;
  logic [DATA_W-1:0]         mem_data_out;

`ifdef MEM_ARB_LOCK_EN
  modport slave (
    input  req, req_rw, req_addr, req_wdata, req_lock, mem_data_out,
    output grant, done, rd_data, busy,
           mem_address, mem_read_write, mem_data_in, mem_enabled
  );
  modport master (
    output req, req_rw, req_addr, req_wdata, req_lock, mem_data_out,
    input  grant, done, rd_data, busy,
           mem_address, mem_read_write, mem_data_in, mem_enabled
  );
`else
  modport slave (
    input  req, req_rw, req_addr, req_wdata, mem_data_out,
    output grant, done, rd_data, busy,
           mem_address, mem_read_write, mem_data_in, mem_enabled
  );
  modport master (
    output req, req_rw, req_addr, req_wdata, mem_data_out,
    input  grant, done, rd_data, busy,
           mem_address, mem_read_write, mem_data_in, mem_enabled
  );
`endif

endinterface

// File: rtl/mem_arbiter_rr_select.sv
// rr_select: combinational rotating-priority picker.
//   req    in  NUM_REQ  request vector
//   last   in  OW       index of the previous owner
//   found  out 1        at least one request is set
//   winner out OW       first set index searching last+1, last+2, ... mod NUM_REQ
module rr_select
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned OW      = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last,
  output logic               found,
  output logic [OW-1:0]      winner
);

  // Scan from the lowest priority (offset NUM_REQ, i.e. last itself) up to
  // the highest (offset 1) so the closest set bit after last overwrites.
  always_comb begin
    int unsigned last_u;
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    last_u = 32'(last);
    idx    = 0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      idx = (last_u + i) % NUM_REQ;
      if (req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer sharing one single-port
// 256x32 memory between NUM_REQ requesters, one access per grant.
//   clk    in  system clock, posedge
//   rst_n  in  synchronous active-low reset
//   bus    mem_arbiter_if.slave (requester handshake + memory lines)
// Optional: MEM_ARB_LOCK_EN adds req_lock for back-to-back owner bursts.
// Timing: req seen in IDLE at t -> mem_enabled at t+1 -> done at t+2.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned OW = owner_w(NUM_REQ);

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_q, last_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              found;
  logic [OW-1:0]     winner;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req    (bus.req),
    .last   (last_q),
    .found  (found),
    .winner (winner)
  );

  // Next-state and latch logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = winner;
          rw_d    = bus.req_rw[winner];
          addr_d  = bus.req_addr[winner*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata[winner*DATA_W +: DATA_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        last_d  = owner_q;
`ifdef MEM_ARB_LOCK_EN
        // Locked owner keeps the bus: relatch its inputs, skip IDLE and
        // leave last untouched so arbitration resumes where it was.
        if (bus.req_lock[owner_q] && bus.req[owner_q]) begin
          state_d = ISSUE;
          last_d  = last_q;
          rw_d    = bus.req_rw[owner_q];
          addr_d  = bus.req_addr[owner_q*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata[owner_q*DATA_W +: DATA_W];
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs. mem_enabled is gated by rst_n so a reset during ISSUE
  // suppresses the access in that same cycle.
  always_comb begin
    bus.grant          = '0;
    bus.done           = '0;
    bus.rd_data        = '0;
    bus.busy           = (state_q != IDLE);
    bus.mem_address    = addr_q;
    bus.mem_read_write = rw_q;
    bus.mem_data_in    = wdata_q;
    bus.mem_enabled    = (state_q == ISSUE) && rst_n;
    if (state_q == ISSUE || state_q == DONE) begin
      bus.grant[owner_q] = 1'b1;
    end
    if (state_q == DONE) begin
      bus.done[owner_q] = 1'b1;
      bus.rd_data       = bus.mem_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
